cp0_unit: RTL and testbench
===========================

Name: cp0_unit

Overview:
- Coprocessor-0 exception/interrupt responder for the MIPS pipeline.
- Evaluates hardware interrupts and synchronous exception codes arriving from the pipeline, and drives IntReq to the fetch unit. The fetch unit then redirects PC to 0x0000_4180.
- Records the victim PC and cause, and returns EPC for eret.
- Sits at the M stage; also serves mfc0/mtc0 reads and writes.

Parameters:
- PRID_VALUE, 32'h0000_2018, constant returned when reading PRId (reg 15).
- RESET_IM, 6'h00, reset value of SR.IM[15:10].

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
- A1  in  5  mfc0 read register index.
- A2  in  5  mtc0 write register index.
- DIn  in  32  mtc0 write data.
- WE  in  1  mtc0 write enable.
- VPC  in  32  PC of the M-stage instruction (the victim).
- BD  in  1  victim is in a branch delay slot.
- ExcCode  in  5  synchronous exception code; 0 = none.
- HWInt  in  6  external interrupt lines [7:2], level-sensitive.
- EXLClr  in  1  eret in M stage.
- IntReq  out  1  take exception/interrupt this cycle (to IFU and pipeline flush).
- EPC  out  32  current EPC register value.
- DOut  out  32  mfc0 read data.

Behaviour:
- Register map:
  - SR (12) = {16'b0, IM[15:10], 8'b0, EXL[1], IE[0]}.
  - Cause (13) = {BD[31], 15'b0, IP[15:10], 3'b0, ExcCode[6:2], 2'b0}.
  - EPC (14): 32 bits.
  - PRId (15) = PRID_VALUE.
  - Any other index reads 0; writes to it are ignored.
- Reset (reset==0 at rising edge): IM=RESET_IM, EXL=0, IE=0, BD=0, IP=0, Cause.ExcCode=0, EPC=0. IntReq is 0 while reset is low.
- IP[15:10] <= HWInt every cycle, including the exception-entry cycle.
- IntReq is combinational:
  - IntPend = IE & ~EXL & |(HWInt & IM).
  - ExcPend = ~EXL & (ExcCode != 0).
  - IntReq = IntPend | ExcPend.
- Entry, on the rising edge where IntReq==1:
  - EXL <= 1.
  - Cause.ExcCode <= IntPend ? 0 : ExcCode. Interrupt has priority over exception.
  - Cause.BD <= BD.
  - EPC <= BD ? {VPC[31:2],2'b00} - 4 : {VPC[31:2],2'b00}.
  - A simultaneous mtc0 (WE=1) is dropped entirely.
- eret: EXLClr=1 and IntReq=0 -> EXL <= 0 at the edge. If IntReq=1 in the same cycle, entry wins and EXL stays 1.
- mtc0, only when IntReq=0:
  - SR: write IM, EXL, IE from DIn.
  - EPC: write {DIn[31:2],2'b00}.
  - Cause and PRId: read-only; writes ignored.
- mfc0: DOut = register[A1], combinational. It reflects the value before the current-edge update; there is no internal write-to-read bypass.
- While EXL=1, all interrupts and exceptions are masked; IntReq=0 regardless of inputs.
- Latency: IntReq in the same cycle as the condition; EPC/Cause visible the cycle after entry.

Optional Feature:
- Macro CP0_TIMER_EN.
- When defined:
  - Adds Count (reg 9) and Compare (reg 11), both 32-bit read/write, reset to 0.
  - Count increments by 1 every cycle and wraps 0xFFFF_FFFF -> 0. An mtc0 write to Count overrides the increment in that cycle.
  - When Count == Compare and Compare != 0, an internal TimerPend flag is set.
  - TimerPend is cleared by any mtc0 write to Compare.
  - TimerPend is OR'd into HWInt[7] for both IP and IntPend.
- When undefined: regs 9/11 read 0, writes are ignored, and there is no timer logic.

Decomposition:
- Shared package/header (extends define.v) holds:
  - CP0 register indices: CP0_SR=12, CP0_CAUSE=13, CP0_EPC=14, CP0_PRID=15, CP0_COUNT=9, CP0_COMPARE=11.
  - SR/Cause field bit positions.
  - Handler address 32'h0000_4180.
  - ExcCode constants: Int=0, AdEL=4, AdES=5, RI=10, Ov=12.
- One natural sub-module: cp0_timer (Count/Compare/TimerPend), instantiated only under CP0_TIMER_EN.

Test Plan:
- Reset low one edge, then high -> SR=0x0000_0000, Cause=0, EPC=0, DOut(A1=15)=PRID_VALUE, IntReq=0.
- Interrupt path: mtc0 SR=0x0000_0401 (IM[10]=1, IE=1), then HWInt=6'b000001 with VPC=0x0000_3010, BD=0 -> IntReq=1 the same cycle; next cycle EPC=0x0000_3010, Cause=0x0000_0400, SR.EXL=1, IntReq=0.
- Delay-slot exception: ExcCode=12, BD=1, VPC=0x0000_3024 -> IntReq=1; next cycle EPC=0x0000_3020, Cause=0x8000_0030.
- Priority and drop: HWInt enabled + ExcCode=10 + WE=1 to EPC (DIn=0x1234) in the same cycle -> ExcCode recorded 0, and EPC=VPC, not 0x1234.
- eret: with EXL=1, pulse EXLClr -> EXL=0 next cycle; HWInt still asserted -> IntReq=1 immediately after.
- CP0_TIMER_EN: mtc0 Compare=5, SR=0x0000_8001 -> IntReq rises when Count reaches 5; mtc0 Compare=100 clears IP[15].

Source files
------------

// File: rtl/cp0_unit_pkg.sv
// Shared CP0 definitions: register indices, SR/Cause field positions,
// the exception handler address and the exception codes.
package cp0_unit_pkg;

  // CP0 register indices
  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_SR      = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;
  localparam logic [4:0] CP0_PRID    = 5'd15;

  // SR field bit positions
  localparam int SR_IE     = 0;
  localparam int SR_EXL    = 1;
  localparam int SR_IM_LO  = 10;
  localparam int SR_IM_HI  = 15;

  // Cause field bit positions
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_BD     = 31;

  // The fetch unit redirects here when IntReq is raised
  localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

  // Exception codes
  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer. Count free-runs and wraps; TimerPend latches when
// Count matches a nonzero Compare and is cleared by any write to Compare.
// Only instantiated when CP0_TIMER_EN is defined.
module cp0_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] din,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        pend
);

  // Count increments every cycle unless overwritten by mtc0
  always_ff @(posedge clk) begin
    if (!reset)        count <= '0;
    else if (count_we) count <= din;
    else               count <= count + 32'd1;
  end

  // Compare is plain software-written state
  always_ff @(posedge clk) begin
    if (!reset)          compare <= '0;
    else if (compare_we) compare <= din;
  end

  // Pending flag: sticky on match, cleared by a Compare write
  always_ff @(posedge clk) begin
    if (!reset)                                     pend <= 1'b0;
    else if (compare_we)                            pend <= 1'b0;
    else if (count == compare && compare != 32'd0)  pend <= 1'b1;
  end

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor-0 exception/interrupt responder at the M stage.
// Raises IntReq combinationally, records EPC/Cause on entry, clears EXL on
// eret and serves mfc0/mtc0. Optional Count/Compare timer under the
// CP0_TIMER_EN macro (timer pending drives interrupt line 7).
module cp0_unit
  import cp0_unit_pkg::*;
#(
  parameter logic [31:0] PRID_VALUE = 32'h0000_2018,
  parameter logic [5:0]  RESET_IM   = 6'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        WE,
  input  logic [31:0] VPC,
  input  logic        BD,
  input  logic [4:0]  ExcCode,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic        IntReq,
  output logic [31:0] EPC,
  output logic [31:0] DOut
);

  logic [5:0]  im, ip;
  logic        exl, ie;
  logic        bd_r;
  logic [4:0]  exc_r;
  logic [31:0] epc_r;

  logic [5:0]  hw_eff;
  logic        int_pend, exc_pend, int_req;
  logic        mtc0;
  logic [31:0] epc_entry;
  logic [31:0] sr_val, cause_val;

`ifdef CP0_TIMER_EN
  logic [31:0] count, compare;
  logic        timer_pend;

  cp0_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .count_we   (mtc0 && A2 == CP0_COUNT),
    .compare_we (mtc0 && A2 == CP0_COMPARE),
    .din        (DIn),
    .count      (count),
    .compare    (compare),
    .pend       (timer_pend)
  );

  assign hw_eff = HWInt | {timer_pend, 5'b0};
`else
  assign hw_eff = HWInt;
`endif

  // Request logic; everything is masked while EXL is set or in reset
  assign int_pend = ie & ~exl & (|(hw_eff & im));
  assign exc_pend = ~exl & (ExcCode != 5'd0);
  assign int_req  = reset & (int_pend | exc_pend);
  assign IntReq   = int_req;

  // An mtc0 colliding with exception entry is dropped
  assign mtc0 = WE & ~int_req;

  // Victim PC, backed up one word when it sits in a delay slot
  assign epc_entry = (VPC & 32'hFFFF_FFFC) - (BD ? 32'd4 : 32'd0);

  // IP tracks the interrupt lines every cycle
  always_ff @(posedge clk) begin
    if (!reset) ip <= '0;
    else        ip <= hw_eff;
  end

  // SR: entry sets EXL, eret clears it, otherwise software writes
  always_ff @(posedge clk) begin
    if (!reset) begin
      im  <= RESET_IM;
      exl <= 1'b0;
      ie  <= 1'b0;
    end else if (int_req) begin
      exl <= 1'b1;
    end else if (mtc0 && A2 == CP0_SR) begin
      im  <= DIn[SR_IM_HI:SR_IM_LO];
      exl <= DIn[SR_EXL];
      ie  <= DIn[SR_IE];
    end else if (EXLClr) begin
      exl <= 1'b0;
    end
  end

  // Cause.BD / Cause.ExcCode captured on entry; interrupt outranks exception
  always_ff @(posedge clk) begin
    if (!reset) begin
      bd_r  <= 1'b0;
      exc_r <= '0;
    end else if (int_req) begin
      bd_r  <= BD;
      exc_r <= int_pend ? EXC_INT : ExcCode;
    end
  end

  // EPC: captured on entry, otherwise word-aligned software write
  always_ff @(posedge clk) begin
    if (!reset)                         epc_r <= '0;
    else if (int_req)                   epc_r <= epc_entry;
    else if (mtc0 && A2 == CP0_EPC)     epc_r <= DIn & 32'hFFFF_FFFC;
  end

  assign EPC = epc_r;

  // Assemble architectural views of SR and Cause
  always_comb begin
    sr_val = '0;
    sr_val[SR_IM_HI:SR_IM_LO] = im;
    sr_val[SR_EXL]            = exl;
    sr_val[SR_IE]             = ie;
    cause_val = '0;
    cause_val[CAUSE_BD]                    = bd_r;
    cause_val[CAUSE_IP_HI:CAUSE_IP_LO]     = ip;
    cause_val[CAUSE_EXC_HI:CAUSE_EXC_LO]   = exc_r;
  end

  // mfc0 read mux: pre-update values, no write bypass
  always_comb begin
    DOut = '0;
    case (A1)
      CP0_SR:      DOut = sr_val;
      CP0_CAUSE:   DOut = cause_val;
      CP0_EPC:     DOut = epc_r;
      CP0_PRID:    DOut = PRID_VALUE;
`ifdef CP0_TIMER_EN
      CP0_COUNT:   DOut = count;
      CP0_COMPARE: DOut = compare;
`endif
      default:     DOut = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Directed-vector bench for cp0_unit with hand-computed expectations.
module tb_cp0_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  A1, A2, ExcCode;
  logic [31:0] DIn, VPC;
  logic        WE, BD, EXLClr;
  logic [5:0]  HWInt;
  logic        IntReq;
  logic [31:0] EPC, DOut;

  int n_vec = 0;
  int n_bad = 0;

  cp0_unit #(.PRID_VALUE(32'h0000_2018), .RESET_IM(6'h00)) dut (
    .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn), .WE(WE),
    .VPC(VPC), .BD(BD), .ExcCode(ExcCode), .HWInt(HWInt), .EXLClr(EXLClr),
    .IntReq(IntReq), .EPC(EPC), .DOut(DOut)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // advance one edge; inputs may change 1ns after the edge
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic rd(input string tag, input logic [4:0] idx, input logic [31:0] exp);
    A1 = idx; #1;
    chk(tag, DOut, exp);
  endtask

  task automatic wr(input logic [4:0] idx, input logic [31:0] d);
    A2 = idx; DIn = d; WE = 1'b1;
    tick();
    WE = 1'b0;
  endtask

  task automatic eret();
    EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0;
  endtask

  initial begin
    reset = 1'b0; A1 = 0; A2 = 0; DIn = 0; WE = 0; VPC = 0; BD = 0;
    ExcCode = 0; HWInt = 0; EXLClr = 0;
    tick();
    ExcCode = 5'd4; #1;
    chk("intreq_in_reset", {31'b0, IntReq}, 32'h0);
    ExcCode = 0;
    tick();
    reset = 1'b1; #1;

    // reset state
    rd("rst_sr", 5'd12, 32'h0);
    rd("rst_cause", 5'd13, 32'h0);
    rd("rst_epc", 5'd14, 32'h0);
    rd("rst_prid", 5'd15, 32'h0000_2018);
    chk("rst_intreq", {31'b0, IntReq}, 32'h0);

    // interrupt path
    wr(5'd12, 32'h0000_0401);
    rd("sr_write", 5'd12, 32'h0000_0401);
    HWInt = 6'b000001; VPC = 32'h0000_3010; BD = 0; #1;
    chk("int_req", {31'b0, IntReq}, 32'h1);
    tick();
    chk("int_epc", EPC, 32'h0000_3010);
    rd("int_cause", 5'd13, 32'h0000_0400);
    rd("int_sr_exl", 5'd12, 32'h0000_0403);
    chk("int_masked_exl", {31'b0, IntReq}, 32'h0);

    // eret with interrupt still asserted re-requests immediately
    eret();
    rd("eret_sr", 5'd12, 32'h0000_0401);
    chk("eret_rereq", {31'b0, IntReq}, 32'h1);
    tick();                       // re-entry
    HWInt = 0;
    eret();
    chk("idle_intreq", {31'b0, IntReq}, 32'h0);

    // delay-slot exception
    ExcCode = 5'd12; BD = 1; VPC = 32'h0000_3024; #1;
    chk("ds_req", {31'b0, IntReq}, 32'h1);
    tick();
    ExcCode = 0; BD = 0;
    chk("ds_epc", EPC, 32'h0000_3020);
    rd("ds_cause", 5'd13, 32'h8000_0030);
    eret();

    // interrupt beats exception; simultaneous mtc0 EPC is dropped
    HWInt = 6'b000001; ExcCode = 5'd10; VPC = 32'h0000_3100;
    A2 = 5'd14; DIn = 32'h0000_1234; WE = 1; #1;
    chk("prio_req", {31'b0, IntReq}, 32'h1);
    tick();
    WE = 0; HWInt = 0; ExcCode = 0;
    chk("prio_epc", EPC, 32'h0000_3100);
    rd("prio_cause", 5'd13, 32'h0000_0400);
    eret();
    rd("eret_cause_ip", 5'd13, 32'h0);

    // software writes: EPC aligned, Cause/PRId/unmapped ignored
    wr(5'd14, 32'h0000_5557);
    chk("mtc0_epc", EPC, 32'h0000_5554);
    wr(5'd13, 32'hFFFF_FFFF);
    rd("cause_ro", 5'd13, 32'h0);
    wr(5'd15, 32'hFFFF_FFFF);
    rd("prid_ro", 5'd15, 32'h0000_2018);
    wr(5'd3, 32'hFFFF_FFFF);
    rd("unmapped", 5'd3, 32'h0);
`ifndef CP0_TIMER_EN
    wr(5'd9, 32'h0000_0055);
    rd("count_absent", 5'd9, 32'h0);
`endif

    // masking by IM and by IE
    wr(5'd12, 32'h0000_0001);
    HWInt = 6'b000001; #1;
    chk("im_mask", {31'b0, IntReq}, 32'h0);
    wr(5'd12, 32'h0000_0400);
    chk("ie_mask", {31'b0, IntReq}, 32'h0);

    // mfc0 sees pre-update value during a write cycle
    A1 = 5'd12; A2 = 5'd12; DIn = 32'h0000_0800; WE = 1; #1;
    chk("no_bypass", DOut, 32'h0000_0400);
    tick();
    WE = 0;
    rd("post_write", 5'd12, 32'h0000_0800);
    HWInt = 0;

`ifdef CP0_TIMER_EN
    begin
      int waited;
      wr(5'd12, 32'h0);
      wr(5'd9, 32'h0);
      wr(5'd11, 32'd5);
      wr(5'd12, 32'h0000_8001);
      waited = 0;
      while (!IntReq && waited < 40) begin tick(); waited++; end
      chk("timer_req", {31'b0, IntReq}, 32'h1);
      tick();                     // entry, EXL=1
      wr(5'd11, 32'd100);
      tick();
      A1 = 5'd13; #1;
      chk("timer_ip_clr", {31'b0, DOut[15]}, 32'h0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
